// File: rtl/LLC_defs.sv
// rtl/LLC_defs.sv - shared LLC snoop types, line geometry and snoop decision helper
package LLC_defs;

  localparam int BYTE_OFFSET = 6;

  typedef enum logic [2:0] {READ, WRITE, INVALIDATE, RWIM, NOBUSOP} busOperation;
  typedef enum logic [1:0] {NOHIT, HIT, HITM, NORESULT} snoopResults;
  typedef enum logic [1:0] {INVALID, SHARED, EXCLUSIVE, MODIFIED} mesi;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, WRITEBACK} snoop_state_t;

  typedef struct packed {
    snoopResults result;
    mesi         next_mesi;
    logic        update;
  } snoop_action_t;

  function automatic snoop_action_t snoop_decide(input busOperation op, input logic hit,
                                                 input mesi cur);
    snoop_action_t act;
    act.result    = NORESULT;
    act.next_mesi = cur;
    act.update    = 1'b0;
    case (op)
      READ, RWIM: begin
        if (hit) begin
          act.result    = (cur == MODIFIED) ? HITM : HIT;
          act.next_mesi = (op == READ) ? SHARED : INVALID;
          act.update    = 1'b1;
        end else begin
          act.result = NOHIT;
        end
      end
      INVALIDATE: begin
        if (hit) begin
          act.next_mesi = INVALID;
          act.update    = 1'b1;
        end
      end
      default: ;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/snoop_tag_array.sv
// rtl/snoop_tag_array.sv - direct-mapped tag + MESI storage, one async read port, one sync write port
module snoop_tag_array
  import LLC_defs::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 32 - BYTE_OFFSET - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output mesi              rd_mesi,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  mesi              wr_mesi
);

  logic [TAG_W-1:0] tag_mem  [ENTRIES];
  mesi              mesi_mem [ENTRIES];

  assign rd_tag  = tag_mem[rd_idx];
  assign rd_mesi = mesi_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]  <= '0;
        mesi_mem[i] <= INVALID;
      end
    end else if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      mesi_mem[wr_idx] <= wr_mesi;
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - bus snoop FSM with write-back sequencer; SNOOP_STATS_EN adds result counters
module snoop_responder
  import LLC_defs::*;
#(
  parameter int ENTRIES  = 16,
  parameter int WB_BEATS = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           bus_valid,
  input  busOperation                                    busOp,
  input  logic [31:0]                                    bus_addr,
  output logic                                           bus_ready,
  output logic                                           snoop_valid,
  output snoopResults                                    snoopResult,
  output logic                                           wb_valid,
  output logic [31:0]                                    wb_addr,
  output logic [(WB_BEATS > 1 ? $clog2(WB_BEATS) : 1)-1:0] wb_beat,
  input  logic                                           wb_ready,
  input  logic                                           fill_valid,
  input  logic [31:0]                                    fill_addr,
  input  mesi                                            fill_mesi,
  output logic                                           fill_ready
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0]                                    snoopHits,
  output logic [31:0]                                    snoopHitms,
  output logic [31:0]                                    snoopMisses
`endif
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = 32 - BYTE_OFFSET - IDX_W;
  localparam int BEAT_W = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WB_BEATS - 1);

  snoop_state_t           state_q, state_d;
  busOperation            op_q;
  logic [31-BYTE_OFFSET:0] line_q;
  snoopResults            result_q;
  logic [31:0]            wb_addr_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   bus_fire, fill_fire, hit, wr_en;
  logic [TAG_W-1:0]       rd_tag, wr_tag;
  logic [IDX_W-1:0]       wr_idx;
  mesi                    rd_mesi, wr_mesi;
  snoop_action_t          act;
  logic                   unused_offset_bits;

  assign unused_offset_bits = ^{bus_addr[BYTE_OFFSET-1:0], fill_addr[BYTE_OFFSET-1:0]};

  snoop_tag_array #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (line_q[IDX_W-1:0]),
    .rd_tag (rd_tag),
    .rd_mesi(rd_mesi),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_tag (wr_tag),
    .wr_mesi(wr_mesi)
  );

  assign hit = (rd_tag == line_q[IDX_W +: TAG_W]) && (rd_mesi != INVALID);
  assign act = snoop_decide(op_q, hit, rd_mesi);

  always_comb begin
    state_d     = state_q;
    bus_ready   = 1'b0;
    fill_ready  = 1'b0;
    snoop_valid = 1'b0;
    wb_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        bus_ready  = !rst;
        fill_ready = !rst && !bus_valid;
        if (bus_valid) state_d = LOOKUP;
      end
      LOOKUP:  state_d = RESPOND;
      RESPOND: begin
        snoop_valid = !rst;
        state_d     = (result_q == HITM) ? WRITEBACK : IDLE;
      end
      WRITEBACK: begin
        wb_valid = !rst;
        if (wb_ready && beat_q == LAST_BEAT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_fire  = bus_valid && bus_ready;
  assign fill_fire = fill_valid && fill_ready;

  // Fills only happen in IDLE and state updates only in LOOKUP, so they never collide
  assign wr_en   = fill_fire || (state_q == LOOKUP && act.update);
  assign wr_idx  = fill_fire ? fill_addr[BYTE_OFFSET +: IDX_W] : line_q[IDX_W-1:0];
  assign wr_tag  = fill_fire ? fill_addr[31 -: TAG_W] : line_q[IDX_W +: TAG_W];
  assign wr_mesi = fill_fire ? fill_mesi : act.next_mesi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= NOBUSOP;
      line_q    <= '0;
      result_q  <= NORESULT;
      wb_addr_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bus_fire) begin
        op_q   <= busOp;
        line_q <= bus_addr[31:BYTE_OFFSET];
      end
      if (state_q == LOOKUP) begin
        result_q <= act.result;
        if (act.result == HITM) wb_addr_q <= {line_q, {BYTE_OFFSET{1'b0}}};
      end
      if (wb_valid && wb_ready) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  assign snoopResult = result_q;
  assign wb_addr     = wb_addr_q;
  assign wb_beat     = beat_q;

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snoopHits   <= '0;
      snoopHitms  <= '0;
      snoopMisses <= '0;
    end else if (state_q == RESPOND) begin
      if (result_q == HIT   && snoopHits   != '1) snoopHits   <= snoopHits + 32'd1;
      if (result_q == HITM  && snoopHitms  != '1) snoopHitms  <= snoopHitms + 32'd1;
      if (result_q == NOHIT && snoopMisses != '1) snoopMisses <= snoopMisses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - vector table, directed corner sequences and random traffic vs a line-state model
module tb_snoop_responder;
  import LLC_defs::*;

  localparam int ENTRIES  = 16;
  localparam int WB_BEATS = 4;
  localparam int IDX_BITS = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  busOperation busOp = NOBUSOP;
  logic [31:0] bus_addr = '0;
  logic        bus_ready, snoop_valid, wb_valid, fill_ready;
  snoopResults snoopResult;
  logic [31:0] wb_addr;
  logic [1:0]  wb_beat;
  logic        wb_ready = 1'b0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_addr = '0;
  mesi         fill_mesi = INVALID;
`ifdef SNOOP_STATS_EN
  logic [31:0] snoopHits, snoopHitms, snoopMisses;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] m_tag [ENTRIES];
  mesi         m_st  [ENTRIES];
  int unsigned m_hits, m_hitms, m_misses;

  snoop_responder #(.ENTRIES(ENTRIES), .WB_BEATS(WB_BEATS)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .busOp(busOp), .bus_addr(bus_addr),
    .bus_ready(bus_ready), .snoop_valid(snoop_valid), .snoopResult(snoopResult),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_beat(wb_beat), .wb_ready(wb_ready),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_mesi(fill_mesi),
    .fill_ready(fill_ready)
`ifdef SNOOP_STATS_EN
    , .snoopHits(snoopHits), .snoopHitms(snoopHitms), .snoopMisses(snoopMisses)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_tag[i] = '0;
      m_st[i]  = INVALID;
    end
    m_hits = 0; m_hitms = 0; m_misses = 0;
  endfunction

  function automatic void model_fill(input logic [31:0] a, input mesi st);
    int idx = int'((a >> BYTE_OFFSET) % ENTRIES);
    m_tag[idx] = a >> (BYTE_OFFSET + IDX_BITS);
    m_st[idx]  = st;
  endfunction

  function automatic snoopResults model_snoop(input busOperation op, input logic [31:0] a);
    int          idx = int'((a >> BYTE_OFFSET) % ENTRIES);
    logic [31:0] tag = a >> (BYTE_OFFSET + IDX_BITS);
    bit          hit = (m_st[idx] != INVALID) && (m_tag[idx] == tag);
    snoopResults r   = NORESULT;
    if (op == READ || op == RWIM) begin
      if (!hit) begin
        r = NOHIT;
        m_misses++;
      end else begin
        if (m_st[idx] == MODIFIED) begin
          r = HITM;
          m_hitms++;
        end else begin
          r = HIT;
          m_hits++;
        end
        m_st[idx] = (op == READ) ? SHARED : INVALID;
      end
    end else if (op == INVALIDATE && hit) begin
      m_st[idx] = INVALID;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus_valid = 1'b0; fill_valid = 1'b0; wb_ready = 1'b0;
    #1;
    check("rst_cycle_bus_ready", bus_ready, 0);
    check("rst_cycle_fill_ready", fill_ready, 0);
    check("rst_cycle_wb_valid", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    check("reset_bus_ready", bus_ready, 1);
    check("reset_fill_ready", fill_ready, 1);
    check("reset_snoop_valid", snoop_valid, 0);
    check("reset_snoop_result", snoopResult, NORESULT);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_addr", wb_addr, 0);
    check("reset_wb_beat", wb_beat, 0);
  endtask

  task automatic fill(input logic [31:0] a, input mesi st);
    int n = 0;
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = a; fill_mesi = st;
    #1;
    check("fill_ready_idle", fill_ready, 1);
    while (!fill_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    fill_valid = 1'b0;
    model_fill(a, st);
  endtask

  // stall0 >= 0: that many wait cycles before beat 0 only; stall0 < 0: random waits per beat
  task automatic snoop(input busOperation op, input logic [31:0] a, input bit use_exp,
                       input snoopResults texp, input int stall0, input int rst_after);
    snoopResults mexp, exp;
    int n = 0;
    int st;
    mexp = model_snoop(op, a);
    exp  = use_exp ? texp : mexp;
    @(negedge clk);
    bus_valid = 1'b1; busOp = op; bus_addr = a;
    #1;
    check("bus_ready_idle", bus_ready, 1);
    check("wb_valid_idle", wb_valid, 0);
    while (!bus_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!bus_ready) begin
      bus_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0;
    #1;
    check("lookup_snoop_valid", snoop_valid, 0);
    @(negedge clk); #1;
    check("respond_snoop_valid", snoop_valid, 1);
    check("respond_result", snoopResult, exp);
    check("respond_bus_ready", bus_ready, 0);
    if (exp != HITM) return;
    for (int b = 0; b < WB_BEATS; b++) begin
      st = (stall0 >= 0) ? ((b == 0) ? stall0 : 0) : int'($urandom_range(0, 2));
      for (int s = 0; s <= st; s++) begin
        @(negedge clk);
        if (s == st) wb_ready = 1'b1;
        #1;
        check("wb_valid", wb_valid, 1);
        check("wb_beat", wb_beat, b);
        check("wb_addr", wb_addr, a & ~32'h3F);
        check("wb_bus_ready", bus_ready, 0);
      end
      @(posedge clk); #1;
      wb_ready = 1'b0;
      if (b == rst_after) begin
        do_reset();
        return;
      end
    end
  endtask

  typedef struct {
    bit          is_fill;
    busOperation op;
    logic [31:0] addr;
    mesi         st;
    snoopResults exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] saved_tag [ENTRIES];
  logic [31:0] ra;

  initial begin
    vecs.push_back('{1, NOBUSOP,    32'h0000_1000, MODIFIED,  NORESULT});
    vecs.push_back('{0, READ,       32'h0000_1000, INVALID,   HITM});
    vecs.push_back('{0, READ,       32'h0000_1000, INVALID,   HIT});
    vecs.push_back('{1, NOBUSOP,    32'h0000_2040, EXCLUSIVE, NORESULT});
    vecs.push_back('{0, RWIM,       32'h0000_2040, INVALID,   HIT});
    vecs.push_back('{0, READ,       32'h0000_2040, INVALID,   NOHIT});
    vecs.push_back('{1, NOBUSOP,    32'h0000_3000, SHARED,    NORESULT});
    vecs.push_back('{0, INVALIDATE, 32'h0000_3000, INVALID,   NORESULT});
    vecs.push_back('{0, READ,       32'h0000_3000, INVALID,   NOHIT});
    vecs.push_back('{1, NOBUSOP,    32'h0000_4080, MODIFIED,  NORESULT});
    vecs.push_back('{0, WRITE,      32'h0000_4080, INVALID,   NORESULT});
    vecs.push_back('{0, READ,       32'h0000_4080, INVALID,   HITM});
    vecs.push_back('{0, RWIM,       32'h0000_4080, INVALID,   HIT});
    vecs.push_back('{1, NOBUSOP,    32'h0000_5000, EXCLUSIVE, NORESULT});
    vecs.push_back('{0, READ,       32'h0000_1000, INVALID,   NOHIT});
    vecs.push_back('{0, NOBUSOP,    32'h0000_5000, INVALID,   NORESULT});
    vecs.push_back('{0, READ,       32'h0000_5000, INVALID,   HIT});
    vecs.push_back('{1, NOBUSOP,    32'h0000_60C0, MODIFIED,  NORESULT});
    vecs.push_back('{0, RWIM,       32'h0000_60C0, INVALID,   HITM});
    vecs.push_back('{0, READ,       32'h0000_60C0, INVALID,   NOHIT});
    vecs.push_back('{0, INVALIDATE, 32'h0000_2040, INVALID,   NORESULT});

    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].is_fill) fill(vecs[i].addr, vecs[i].st);
      else snoop(vecs[i].op, vecs[i].addr, 1'b1, vecs[i].exp, 0, -1);
    end

    // Bus request and fill in the same IDLE cycle: bus wins, fill waits for the next IDLE
    @(negedge clk);
    bus_valid = 1'b1; busOp = READ; bus_addr = 32'h0000_7100;
    fill_valid = 1'b1; fill_addr = 32'h0000_7000; fill_mesi = MODIFIED;
    #1;
    check("prio_bus_ready", bus_ready, 1);
    check("prio_fill_ready", fill_ready, 0);
    void'(model_snoop(READ, 32'h0000_7100));
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0;
    #1;
    check("prio_lookup_fill_ready", fill_ready, 0);
    @(negedge clk); #1;
    check("prio_respond_valid", snoop_valid, 1);
    check("prio_respond_result", snoopResult, NOHIT);
    check("prio_respond_fill_ready", fill_ready, 0);
    @(negedge clk); #1;
    check("prio_idle_fill_ready", fill_ready, 1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    model_fill(32'h0000_7000, MODIFIED);
    snoop(READ, 32'h0000_7000, 1'b1, HITM, 0, -1);

    fill(32'h0000_9000, MODIFIED);
    snoop(READ, 32'h0000_9000, 1'b1, HITM, 3, -1);

    for (int k = 0; k < 300; k++) begin
      ra = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      if ($urandom_range(0, 2) == 0) fill(ra, mesi'($urandom_range(0, 3)));
      else snoop(busOperation'($urandom_range(0, 4)), ra, 1'b0, NORESULT, -1, -1);
    end

`ifdef SNOOP_STATS_EN
    @(negedge clk); #1;
    check("stats_hits", snoopHits, m_hits);
    check("stats_hitms", snoopHitms, m_hitms);
    check("stats_misses", snoopMisses, m_misses);
`endif

    // Reset in the middle of a write-back, then every previously held line must miss
    fill(32'h0000_A040, MODIFIED);
    for (int i = 0; i < ENTRIES; i++) saved_tag[i] = m_tag[i];
    snoop(READ, 32'h0000_A040, 1'b1, HITM, 0, 1);
    for (int i = 0; i < ENTRIES; i++)
      snoop(READ, (saved_tag[i] << (BYTE_OFFSET + IDX_BITS)) | (i << BYTE_OFFSET),
            1'b1, NOHIT, 0, -1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
